// File: rtl/cmd_sched_if.sv
// Bundle between cmd_sched and its environment: the NREQ requesters and the
// snd_cmd command sender. The slave modport belongs to the scheduler. The
// master modport belongs to the environment, which drives the requests and
// resp_rcvd.
interface cmd_sched_if #(
    parameter int NREQ = 4
);
    // Handshake: a requester raises req[i] with stable req_start/req_len
    // fields and holds it. gnt[i] stays high for the whole transaction.
    // send pulses once per issued attempt. resp_rcvd is honoured only while
    // waiting. Exactly one of done[i]/err[i] pulses for one cycle to end the
    // transaction, and the requester then drops req[i]. A req left high is
    // taken as a fresh request.
    logic [NREQ-1:0]   req;
    logic [5*NREQ-1:0] req_start;
    logic [4*NREQ-1:0] req_len;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              send;
    logic [4:0]        cmd_start;
    logic [3:0]        cmd_len;
    logic              resp_rcvd;
    logic              busy;
    logic [1:0]        dbg_state;   // 0 IDLE, 1 ISSUE, 2 WAIT, 3 CMPL

    modport slave (
        input  req, req_start, req_len, resp_rcvd,
        output gnt, done, err, send, cmd_start, cmd_len, busy, dbg_state
    );

    modport master (
        output req, req_start, req_len, resp_rcvd,
        input  gnt, done, err, send, cmd_start, cmd_len, busy, dbg_state
    );
endinterface

// File: rtl/cmd_sched.sv
// cmd_sched: round-robin scheduler that shares one snd_cmd sender among NREQ
// requesters, with at most one command in flight at a time.
// Optional macro CMD_RETRY_EN: on a timeout, reissue the command up to
// MAX_RETRY times before reporting err.
// Every output is registered. The FSM state is visible on sched.dbg_state.
module cmd_sched #(
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = 1000000,
    parameter int TMR_W     = 20,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    cmd_sched_if.slave sched
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Catch illegal configurations at elaboration time.
    if (NREQ < 2 || NREQ > 8 || MAX_RETRY < 0 || TIMEOUT < 1 ||
        (64'(TIMEOUT) >= (64'(1) << TMR_W))) begin : g_bad_param
        $error("cmd_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CMPL  = 2'd3
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [PW-1:0]     sel_q;
    logic [TMR_W-1:0]  timer_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic [NREQ-1:0]   err_q;
    logic              send_q;
    logic              busy_q;
    logic [4:0]        cmd_start_q;
    logic [3:0]        cmd_len_q;

`ifdef CMD_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0]     retry_q;
`endif

    // Arbitration result for the next grant.
    logic              sel_vld_d;
    logic [PW-1:0]     sel_d;
    logic [4:0]        start_d;
    logic [3:0]        len_d;
    logic              timeout_hit;

    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

    // Round-robin pick. The first pass covers indices at or above rr_ptr and
    // the second pass wraps around to the lower ones.
    always_comb begin
        sel_vld_d = 1'b0;
        sel_d     = '0;
        start_d   = 5'h00;
        len_d     = 4'h0;
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_vld_d && sched.req[i] && (PW'(i) >= rr_ptr_q)) begin
                sel_vld_d = 1'b1;
                sel_d     = PW'(i);
                start_d   = sched.req_start[5*i +: 5];
                len_d     = sched.req_len[4*i +: 4];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_vld_d && sched.req[i]) begin
                sel_vld_d = 1'b1;
                sel_d     = PW'(i);
                start_d   = sched.req_start[5*i +: 5];
                len_d     = sched.req_len[4*i +: 4];
            end
        end
    end

    // Scheduler FSM. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            timer_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            send_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_start_q <= 5'h00;
            cmd_len_q   <= 4'h0;
`ifdef CMD_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef CMD_RETRY_EN
                    retry_q <= '0;
`endif
                    if (sel_vld_d) begin
                        sel_q       <= sel_d;
                        gnt_q       <= NREQ'(1) << sel_d;
                        cmd_start_q <= start_d;
                        cmd_len_q   <= len_d;
                        send_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    send_q  <= 1'b0;
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (sched.resp_rcvd) begin
                        done_q  <= gnt_q;
                        state_q <= CMPL;
                    end else if (timeout_hit) begin
`ifdef CMD_RETRY_EN
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_q <= retry_q + RW'(1);
                            send_q  <= 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            err_q   <= gnt_q;
                            state_q <= CMPL;
                        end
`else
                        err_q   <= gnt_q;
                        state_q <= CMPL;
`endif
                    end
                end
                CMPL: begin
                    done_q   <= '0;
                    err_q    <= '0;
                    gnt_q    <= '0;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + PW'(1);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sched.gnt       = gnt_q;
    assign sched.done      = done_q;
    assign sched.err       = err_q;
    assign sched.send      = send_q;
    assign sched.busy      = busy_q;
    assign sched.cmd_start = cmd_start_q;
    assign sched.cmd_len   = cmd_len_q;
    assign sched.dbg_state = state_q;
endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched (NREQ=4, TIMEOUT=16). The retry scenarios are
// built when CMD_RETRY_EN is defined.
module tb_cmd_sched;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cmd_sched_if #(.NREQ(NREQ)) sched();

    cmd_sched #(
        .NREQ(NREQ), .TIMEOUT(16), .TMR_W(5), .MAX_RETRY(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sched (sched.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int send_cnt = 0;
    int send_bad = 0;
    int s0;

    logic [4:0] st_tab [NREQ] = '{5'h10, 5'h04, 5'h12, 5'h1F};
    logic [3:0] ln_tab [NREQ] = '{4'h1, 4'h3, 4'h5, 4'hF};
    logic [1:0] exp_q [$];
    logic [1:0] e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_send(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (sched.send !== 1'b1 && k < 40);
        check_eq({tag, " send"}, 32'(sched.send), 32'd1);
    endtask

    // Count every send pulse and flag any that appears outside ISSUE.
    always @(negedge clk) begin
        if (rst_n && sched.send === 1'b1) begin
            send_cnt++;
            if (sched.dbg_state !== 2'd1) send_bad++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sched.req       = '0;
        sched.resp_rcvd = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sched.req_start[5*i +: 5] = st_tab[i];
            sched.req_len[4*i +: 4]   = ln_tab[i];
        end

        // Reset values
        repeat (3) tick();
        check_eq("rst gnt",       32'(sched.gnt), 0);
        check_eq("rst done_err",  32'({sched.done, sched.err}), 0);
        check_eq("rst send_busy", 32'({sched.send, sched.busy}), 0);
        check_eq("rst cmd",       32'({sched.cmd_start, sched.cmd_len}), 0);
        check_eq("rst state",     32'(sched.dbg_state), 0);
        rst_n = 1'b1;

        // Single transaction, requester 1, answered in WAIT
        sched.req = 4'b0010;
        wait_send("t1");
        check_eq("t1 gnt",       32'(sched.gnt), 32'h2);
        check_eq("t1 cmd_start", 32'(sched.cmd_start), 32'h04);
        check_eq("t1 cmd_len",   32'(sched.cmd_len), 32'h3);
        check_eq("t1 busy",      32'(sched.busy), 1);
        tick();
        check_eq("t1 send oneshot", 32'(sched.send), 0);
        check_eq("t1 gnt held",     32'(sched.gnt), 32'h2);
        repeat (9) tick();
        sched.resp_rcvd = 1'b1;
        tick();
        sched.resp_rcvd = 1'b0;
        check_eq("t1 done", 32'(sched.done), 32'h2);
        check_eq("t1 err",  32'(sched.err), 0);
        check_eq("t1 gnt cmpl", 32'(sched.gnt), 32'h2);
        sched.req = '0;
        tick();
        check_eq("t1 idle outs", 32'({sched.gnt, sched.done, sched.busy}), 0);

        // Response while IDLE is ignored; command fields hold
        sched.resp_rcvd = 1'b1;
        tick();
        sched.resp_rcvd = 1'b0;
        tick();
        check_eq("idle resp outs", 32'({sched.gnt, sched.done, sched.err, sched.send, sched.busy}), 0);
        check_eq("idle cmd hold",  32'({sched.cmd_start, sched.cmd_len}), 32'({5'h04, 4'h3}));

        // Round robin with all requesters held, from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        s0 = send_cnt;
        sched.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_send("rr");
            e = exp_q.pop_front();
            check_eq("rr gnt",       32'(sched.gnt), 32'(1) << e);
            check_eq("rr cmd_start", 32'(sched.cmd_start), 32'(st_tab[e]));
            check_eq("rr cmd_len",   32'(sched.cmd_len), 32'(ln_tab[e]));
            tick();
            sched.resp_rcvd = 1'b1;
            tick();
            sched.resp_rcvd = 1'b0;
            check_eq("rr done", 32'(sched.done), 32'(1) << e);
            if (g == 4) sched.req = '0;
            tick();
        end
        check_eq("rr send count", 32'(send_cnt - s0), 5);

`ifndef CMD_RETRY_EN
        // Timeout: no response, err after 16 WAIT cycles
        sched.req = 4'b0100;
        wait_send("to");
        check_eq("to gnt", 32'(sched.gnt), 32'h4);
        repeat (16) tick();
        check_eq("to no early err", 32'(sched.err), 0);
        check_eq("to busy",         32'(sched.busy), 1);
        tick();
        check_eq("to err",  32'(sched.err), 32'h4);
        check_eq("to done", 32'(sched.done), 0);
        sched.req = '0;
        tick();
        check_eq("to idle", 32'({sched.err, sched.gnt, sched.busy}), 0);
`endif

        // Response on the timeout cycle wins; rr_ptr sits past requester 0
        sched.req = 4'b1001;
        wait_send("co");
        check_eq("co gnt", 32'(sched.gnt), 32'h8);
        repeat (16) tick();
        sched.resp_rcvd = 1'b1;
        tick();
        sched.resp_rcvd = 1'b0;
        check_eq("co done", 32'(sched.done), 32'h8);
        check_eq("co err",  32'(sched.err), 0);
        sched.req = '0;
        tick();

        // Reset in the middle of WAIT, then re-arbitration from requester 0
        sched.req = 4'b0110;
        wait_send("mr1");
        check_eq("mr1 gnt", 32'(sched.gnt), 32'h2);
        tick();
        sched.resp_rcvd = 1'b1;
        tick();
        sched.resp_rcvd = 1'b0;
        check_eq("mr1 done", 32'(sched.done), 32'h2);
        tick();
        wait_send("mr2");
        check_eq("mr2 gnt", 32'(sched.gnt), 32'h4);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mr async outs", 32'({sched.gnt, sched.done, sched.err, sched.send, sched.busy}), 0);
        check_eq("mr async cmd",  32'({sched.cmd_start, sched.cmd_len}), 0);
        tick();
        rst_n = 1'b1;
        wait_send("mr3");
        check_eq("mr3 gnt", 32'(sched.gnt), 32'h2);
        tick();
        sched.resp_rcvd = 1'b1;
        tick();
        sched.resp_rcvd = 1'b0;
        check_eq("mr3 done", 32'(sched.done), 32'h2);
        sched.req = '0;
        tick();

`ifdef CMD_RETRY_EN
        // Two unanswered attempts, the third answered
        s0 = send_cnt;
        sched.req = 4'b0001;
        for (int a = 0; a < 3; a++) begin
            wait_send("ra");
            check_eq("ra gnt", 32'(sched.gnt), 32'h1);
            check_eq("ra cmd", 32'({sched.cmd_start, sched.cmd_len}), 32'({5'h10, 4'h1}));
            check_eq("ra err", 32'(sched.err), 0);
        end
        tick();
        sched.resp_rcvd = 1'b1;
        tick();
        sched.resp_rcvd = 1'b0;
        check_eq("ra done", 32'(sched.done), 32'h1);
        check_eq("ra err end", 32'(sched.err), 0);
        check_eq("ra sends", 32'(send_cnt - s0), 3);
        sched.req = '0;
        tick();

        // All attempts unanswered
        sched.req = 4'b0001;
        for (int a = 0; a < 3; a++) begin
            wait_send("rb");
            check_eq("rb gnt", 32'(sched.gnt), 32'h1);
        end
        repeat (16) tick();
        check_eq("rb no early err", 32'(sched.err), 0);
        tick();
        check_eq("rb err",  32'(sched.err), 32'h1);
        check_eq("rb done", 32'(sched.done), 0);
        sched.req = '0;
        tick();
`endif

        check_eq("send only in ISSUE", 32'(send_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
